// File: rtl/spi_slave.sv
// spi_slave: SPI slave endpoint. All state lives in the clk domain. spi_clk,
// cs_n and mosi are brought in through 2-flop synchronizers, and SPI edges are
// detected on the synchronized copies.
//
// Parameters
//   WIDTH     : bits per word (4..32)
//   CPOL      : idle level of spi_clk
//   CPHA      : 0 = sample on leading edge, 1 = sample on trailing edge
//   MSB_FIRST : 1 = MSB first on mosi/miso, 0 = LSB first
//
// Ports
//   clk, rst            : system clock, synchronous active-low reset
//   spi_clk, cs_n, mosi : asynchronous SPI inputs
//   miso                : slave serial output, 0 unless ARMED
//   tx_data, tx_valid   : next word to send
//   tx_ready            : one-cycle pulse when tx_data is taken
//   rx_data, rx_valid   : last complete word, plus a one-cycle update pulse
//   rx_ready            : consumer acknowledge for the current rx_data
//   overrun             : pulses with rx_valid when the prior word was never acked
//   busy                : high exactly while ARMED
//   o_dbg_state         : current FSM state, for observation
//
// Handshake semantics:
//   tx side: at each word boundary, tx_data is taken if and only if tx_valid is
//   high. tx_ready pulses for one cycle in the cycle after the capture. A missing
//   tx_valid sends zeros and is not an error.
//   rx side: rx_valid pulses once per complete word. Holding rx_ready high in any
//   cycle from that pulse until the next word completes acknowledges the word.
module spi_slave #(
  parameter int   WIDTH     = 8,
  parameter logic CPOL      = 1'b0,
  parameter logic CPHA      = 1'b0,
  parameter logic MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_clk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             overrun,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_WAIT_CS = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Synchronizers and previous-value flops used for edge detection.
  logic r_sclk_meta, r_sclk_sync, r_sclk_prev;
  logic r_cs_meta, r_cs_sync, r_cs_prev;
  logic r_mosi_meta, r_mosi_sync;

  // Counts clk cycles after reset, saturating at 2. Until the count reaches 2,
  // the synchronizer still holds its reset value of 1 rather than the real
  // cs_n level. WAIT_CS must not treat that reset value as "cs_n seen high",
  // or a transfer that was in progress when reset hit would be picked up again.
  logic [1:0] r_flush;

  logic [WIDTH-1:0] r_rx_sr;
  logic [WIDTH-1:0] r_tx_sr;
  logic [WIDTH-1:0] r_rx_data;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_rx_valid;
  logic             r_tx_ready;
  logic             r_overrun;
  logic             r_pending;   // current rx_data not yet acknowledged
  logic             r_skip;      // suppress the next shift edge

  logic w_lead, w_trail, w_sample, w_shift;
  logic w_cs_fall, w_cs_rise, w_flushed;
  logic w_sample_ok, w_shift_ok, w_word_done, w_arm, w_boundary;
  logic [WIDTH-1:0] w_rx_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sclk_meta <= CPOL;
      r_sclk_sync <= CPOL;
      r_sclk_prev <= CPOL;
      r_cs_meta   <= 1'b1;
      r_cs_sync   <= 1'b1;
      r_cs_prev   <= 1'b1;
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
      r_flush     <= 2'd0;
    end else begin
      r_sclk_meta <= spi_clk;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_prev <= r_sclk_sync;
      r_cs_meta   <= cs_n;
      r_cs_sync   <= r_cs_meta;
      r_cs_prev   <= r_cs_sync;
      r_mosi_meta <= mosi;
      r_mosi_sync <= r_mosi_meta;
      if (r_flush != 2'd2) r_flush <= r_flush + 2'd1;
    end
  end

  assign w_lead    = (r_sclk_sync != CPOL) && (r_sclk_prev == CPOL);
  assign w_trail   = (r_sclk_sync == CPOL) && (r_sclk_prev != CPOL);
  assign w_sample  = CPHA ? w_trail : w_lead;
  assign w_shift   = CPHA ? w_lead  : w_trail;
  assign w_cs_fall = r_cs_prev & ~r_cs_sync;
  assign w_cs_rise = ~r_cs_prev & r_cs_sync;
  assign w_flushed = (r_flush == 2'd2);

  // A cs_n rise in the same cycle as a sample edge wins: the sample is dropped.
  assign w_sample_ok = (r_state == S_ARMED) && w_sample && !w_cs_rise;
  assign w_shift_ok  = (r_state == S_ARMED) && w_shift && !w_cs_rise;
  assign w_word_done = w_sample_ok && (r_bit_cnt == LAST_BIT);
  assign w_arm       = (r_state == S_IDLE) && w_cs_fall;
  assign w_boundary  = w_arm || w_word_done;

  assign w_rx_next = MSB_FIRST ? {r_rx_sr[WIDTH-2:0], r_mosi_sync}
                               : {r_mosi_sync, r_rx_sr[WIDTH-1:1]};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_WAIT_CS;
    else      r_state <= w_next_state;
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_WAIT_CS: if (w_flushed && r_cs_sync) w_next_state = S_IDLE;
      S_IDLE:    if (w_cs_fall)              w_next_state = S_ARMED;
      S_ARMED:   if (w_cs_rise)              w_next_state = S_IDLE;
      default:                               w_next_state = S_WAIT_CS;
    endcase
  end

  // Receive path, acknowledge tracking, transmit shift register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_sr    <= '0;
      r_tx_sr    <= '0;
      r_rx_data  <= '0;
      r_bit_cnt  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_ready <= 1'b0;
      r_overrun  <= 1'b0;
      r_pending  <= 1'b0;
      r_skip     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_ready <= 1'b0;
      r_overrun  <= 1'b0;

      // Leaving ARMED, or never having entered it, drops any partial word.
      if ((r_state != S_ARMED) || w_cs_rise) begin
        r_bit_cnt <= '0;
      end else if (w_sample_ok) begin
        r_rx_sr <= w_rx_next;
        if (w_word_done) begin
          r_bit_cnt  <= '0;
          r_rx_data  <= w_rx_next;
          r_rx_valid <= 1'b1;
          r_overrun  <= r_pending && !rx_ready;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end

      if (w_word_done)   r_pending <= 1'b1;
      else if (rx_ready) r_pending <= 1'b0;

      // In CPHA=0 the slave has already presented bit 0 of the new word by the
      // time of the shift edge that follows a wrap, so that edge is skipped.
      // In CPHA=1 the first shift edge of every word only opens the bit
      // window, so that edge is always skipped.
      if (w_boundary) begin
        r_tx_sr    <= tx_valid ? tx_data : '0;
        r_tx_ready <= tx_valid;
        r_skip     <= CPHA || w_word_done;
      end else if (w_shift_ok) begin
        if (r_skip)         r_skip  <= 1'b0;
        else if (MSB_FIRST) r_tx_sr <= {r_tx_sr[WIDTH-2:0], 1'b0};
        else                r_tx_sr <= {1'b0, r_tx_sr[WIDTH-1:1]};
      end
    end
  end

  assign miso        = (r_state == S_ARMED) ?
                       (MSB_FIRST ? r_tx_sr[WIDTH-1] : r_tx_sr[0]) : 1'b0;
  assign busy        = (r_state == S_ARMED);
  assign tx_ready    = r_tx_ready;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign overrun     = r_overrun;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: three spi_slave instances, one per configuration under test.
//   u0: WIDTH=8,  CPOL=0, CPHA=0, MSB first
//   u1: WIDTH=8,  CPOL=1, CPHA=1, MSB first
//   u2: WIDTH=16, CPOL=0, CPHA=0, LSB first
// A bit-level SPI master drives one instance at a time. The master pushes
// expected received words into exp_q, and a monitor pops them on rx_valid. The
// expected overrun flag comes from a per-instance "unacknowledged" model. A
// feeder presents the head of tx_q and pops it on tx_ready.
module tb_spi_slave;
  localparam int H = 6;  // clk periods per spi_clk phase

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] sclk, cs_n, mosi, miso, tx_valid, tx_ready;
  logic [2:0] rx_valid, rx_ready, overrun, busy;
  logic [31:0] tx_dat [3];
  logic [7:0]  rxd0, rxd1;
  logic [15:0] rxd2;
  logic [1:0]  dbg0, dbg1, dbg2;

  spi_slave #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .rst(rst), .spi_clk(sclk[0]), .cs_n(cs_n[0]), .mosi(mosi[0]),
    .miso(miso[0]), .tx_data(tx_dat[0][7:0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .rx_data(rxd0), .rx_valid(rx_valid[0]),
    .rx_ready(rx_ready[0]), .overrun(overrun[0]), .busy(busy[0]), .o_dbg_state(dbg0));

  spi_slave #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .spi_clk(sclk[1]), .cs_n(cs_n[1]), .mosi(mosi[1]),
    .miso(miso[1]), .tx_data(tx_dat[1][7:0]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .rx_data(rxd1), .rx_valid(rx_valid[1]),
    .rx_ready(rx_ready[1]), .overrun(overrun[1]), .busy(busy[1]), .o_dbg_state(dbg1));

  spi_slave #(.WIDTH(16), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .rst(rst), .spi_clk(sclk[2]), .cs_n(cs_n[2]), .mosi(mosi[2]),
    .miso(miso[2]), .tx_data(tx_dat[2][15:0]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .rx_data(rxd2), .rx_valid(rx_valid[2]),
    .rx_ready(rx_ready[2]), .overrun(overrun[2]), .busy(busy[2]), .o_dbg_state(dbg2));

  int n_checks = 0;
  int n_errors = 0;
  logic [34:0] exp_q[$];        // {instance[1:0], overrun, word[31:0]}
  logic [31:0] tx_q[$];
  int          cur_d = 0;
  int          tx_seen = 0;
  bit          unacked [3];
  logic [31:0] last_rx [3];
  logic [31:0] mosi_w [4];
  logic [31:0] tx_w [4];

  function automatic int p_w(input int d);
    return (d == 2) ? 16 : 8;
  endfunction
  function automatic logic p_cpol(input int d);
    return (d == 1);
  endfunction
  function automatic logic p_cpha(input int d);
    return (d == 1);
  endfunction
  function automatic logic p_msb(input int d);
    return (d != 2);
  endfunction
  function automatic logic [31:0] mask(input int w);
    logic [31:0] one;
    one = 32'd1;
    return (w >= 32) ? 32'hFFFF_FFFF : ((one << w) - 32'd1);
  endfunction
  function automatic logic [31:0] get_rx(input int d);
    case (d)
      0:       return 32'(rxd0);
      1:       return 32'(rxd1);
      default: return 32'(rxd2);
    endcase
  endfunction

  task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: rx scoreboard, tx_ready counting, tx feeder.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rx_valid[d]) begin
        if (exp_q.size() == 0) begin
          check("rx_valid_unexpected", 35'(rx_valid[d]), 35'd0);
        end else begin
          check("rx_word", {2'(d), overrun[d], get_rx(d)}, exp_q.pop_front());
        end
      end else if (overrun[d]) begin
        check("overrun_without_rx_valid", 35'(overrun[d]), 35'd0);
      end
      if (tx_ready[d]) tx_seen++;
    end
    if (tx_ready[cur_d] && tx_q.size() > 0) void'(tx_q.pop_front());
    for (int d = 0; d < 3; d++) begin
      tx_valid[d] = (d == cur_d) && (tx_q.size() > 0);
      tx_dat[d]   = tx_valid[d] ? tx_q[0] : 32'd0;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SPI bit as a mode-correct master: m is miso as seen at the sample edge.
  task automatic spi_bit(input int d, input logic b, output logic m);
    if (!p_cpha(d)) begin
      mosi[d] = b;
      wait_clk(H);
      m = miso[d];
      sclk[d] = ~p_cpol(d);
      wait_clk(H);
      sclk[d] = p_cpol(d);
    end else begin
      sclk[d] = ~p_cpol(d);
      mosi[d] = b;
      wait_clk(H);
      m = miso[d];
      sclk[d] = p_cpol(d);
      wait_clk(H);
    end
  endtask

  // Frame of nw words. The last word carries only nbits bits; nbits < width
  // makes it a partial word that is discarded when cs_n rises.
  task automatic run_frame(input int d, input int nw, input int nbits,
                           input bit rr, input bit use_tx);
    int w, nb, bi, full, exp_tx;
    logic m;
    logic [31:0] got;
    w = p_w(d);
    cur_d = d;
    tx_q.delete();
    if (use_tx) for (int k = 0; k < nw; k++) tx_q.push_back(tx_w[k] & mask(w));
    rx_ready[d] = rr;
    if (rr) unacked[d] = 1'b0;
    wait_clk(3);
    tx_seen = 0;
    cs_n[d] = 1'b0;
    wait_clk(H);
    for (int k = 0; k < nw; k++) begin
      nb = (k == nw - 1) ? nbits : w;
      if (nb == w) begin
        exp_q.push_back({2'(d), unacked[d], mosi_w[k] & mask(w)});
        unacked[d] = !rr;
        last_rx[d] = mosi_w[k] & mask(w);
      end
      got = 32'd0;
      for (int i = 0; i < nb; i++) begin
        bi = p_msb(d) ? (w - 1 - i) : i;
        spi_bit(d, mosi_w[k][bi], m);
        got[bi] = m;
        if (k == 0 && i == 0) check("busy_in_frame", 35'(busy[d]), 35'd1);
      end
      if (nb == w) check("miso_word", 35'(got), 35'(use_tx ? (tx_w[k] & mask(w)) : 32'd0));
    end
    wait_clk(H);
    cs_n[d] = 1'b1;
    wait_clk(12);
    full   = (nbits == w) ? nw : nw - 1;
    exp_tx = use_tx ? ((nw < full + 1) ? nw : full + 1) : 0;
    check("busy_after_cs", 35'(busy[d]), 35'd0);
    check("rx_data_hold", 35'(get_rx(d)), 35'(last_rx[d]));
    check("tx_ready_count", 35'(tx_seen), 35'(exp_tx));
    check("scoreboard_drained", 35'(exp_q.size()), 35'd0);
  endtask

  initial begin
    logic m;
    int d, nw, w, nbits;
    rst = 1'b0;
    sclk = 3'b010;
    cs_n = 3'b111;
    mosi = 3'b000;
    rx_ready = 3'b000;
    for (int i = 0; i < 3; i++) begin
      unacked[i] = 1'b0;
      last_rx[i] = 32'd0;
    end
    wait_clk(4);
    for (int i = 0; i < 3; i++) begin
      check("reset_rx_data", 35'(get_rx(i)), 35'd0);
      check("reset_flags", 35'({rx_valid[i], tx_ready[i], overrun[i], busy[i], miso[i]}), 35'd0);
    end
    rst = 1'b1;
    wait_clk(6);

    // Mode 0 single word with a tx word queued before cs_n falls.
    mosi_w[0] = 32'hCB; tx_w[0] = 32'hD2;
    run_frame(0, 1, 8, 1'b1, 1'b1);

    // Back-to-back words, never acknowledged: the second word overruns.
    mosi_w[0] = 32'hCB; mosi_w[1] = 32'hF0;
    run_frame(0, 2, 8, 1'b0, 1'b0);

    // CPOL=1, CPHA=1.
    mosi_w[0] = 32'hA5; tx_w[0] = 32'h3C;
    run_frame(1, 1, 8, 1'b1, 1'b1);

    // Aborted word after 5 bits, then a full word.
    mosi_w[0] = 32'h77;
    run_frame(0, 1, 5, 1'b1, 1'b0);
    mosi_w[0] = 32'h81;
    run_frame(0, 1, 8, 1'b1, 1'b0);

    // Reset during a transfer while cs_n stays low.
    cur_d = 0;
    tx_q.delete();
    rx_ready[0] = 1'b1;
    wait_clk(3);
    tx_seen = 0;
    cs_n[0] = 1'b0;
    wait_clk(H);
    for (int i = 0; i < 3; i++) spi_bit(0, 1'($urandom_range(0, 1)), m);
    rst = 1'b0;
    wait_clk(2);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      unacked[i] = 1'b0;
      last_rx[i] = 32'd0;
    end
    wait_clk(1);
    check("rx_data_after_rst", 35'(get_rx(0)), 35'd0);
    for (int i = 0; i < 8; i++) spi_bit(0, 1'($urandom_range(0, 1)), m);
    wait_clk(4);
    check("busy_wait_cs", 35'(busy[0]), 35'd0);
    check("tx_ready_during_wait_cs", 35'(tx_seen), 35'd0);
    cs_n[0] = 1'b1;
    wait_clk(12);
    mosi_w[0] = 32'h5A;
    run_frame(0, 1, 8, 1'b1, 1'b0);

    // 16-bit LSB-first instance, no tx data offered.
    mosi_w[0] = 32'h1234;
    run_frame(2, 1, 16, 1'b1, 1'b0);

    // Randomized frames across all three configurations.
    for (int r = 0; r < 12; r++) begin
      d  = $urandom_range(0, 2);
      w  = p_w(d);
      nw = $urandom_range(1, 3);
      nbits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, w - 1) : w;
      for (int k = 0; k < 4; k++) begin
        mosi_w[k] = $urandom() & mask(w);
        tx_w[k]   = $urandom() & mask(w);
      end
      run_frame(d, nw, nbits, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
